// File: rtl/io_port_bank_pkg.sv
// Shared register map for the memory-mapped I/O port bank.
package io_port_pkg;

  localparam int REGS_PER_PORT = 4;

  typedef enum logic [1:0] {
    IO_REG_IN    = 2'd0,
    IO_REG_OUT   = 2'd1,
    IO_REG_FLAGS = 2'd2,
    IO_REG_MASK  = 2'd3
  } io_reg_e;

endpackage

// File: rtl/io_port_bank_if.sv
// CPU data-bus side of the I/O port bank: strobes, address, write data and registered read data.
interface io_port_bank_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  in_write_en;
  logic                  in_read_en;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [DATA_WIDTH-1:0] in_data;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_data_valid;

  modport master (
    output in_write_en, in_read_en, in_addr, in_data,
    input  out_data, out_data_valid
  );

  modport slave (
    input  in_write_en, in_read_en, in_addr, in_data,
    output out_data, out_data_valid
  );
endinterface

// File: rtl/io_port_bank_sync_edge.sv
// Two-flop pin synchronizer plus a previous-value flop; edge_vec flags any change of the synced value.
module io_sync_edge #(
  parameter int PORT_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PORT_WIDTH-1:0] pin,
  output logic [PORT_WIDTH-1:0] sync_val,
  output logic [PORT_WIDTH-1:0] edge_vec
);
  logic [PORT_WIDTH-1:0] meta_reg;
  logic [PORT_WIDTH-1:0] sync_reg;
  logic [PORT_WIDTH-1:0] prev_reg;

  // All stages clear together so releasing reset cannot fake an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= '0;
      sync_reg <= '0;
      prev_reg <= '0;
    end else begin
      meta_reg <= pin;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign sync_val = sync_reg;
  assign edge_vec = sync_reg ^ prev_reg;
endmodule

// File: rtl/io_port_bank.sv
// Parametrised I/O port bank: per channel IN/OUT/FLAGS/MASK registers, registered read mux and irq.
module io_port_bank
  import io_port_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PORT_WIDTH = 4,
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  io_port_bank_if.slave                   bus,
  input  logic [NUM_PORTS*PORT_WIDTH-1:0] in_port,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] out_port,
  output logic                            out_irq
);
  localparam int NUM_REGS = NUM_PORTS * REGS_PER_PORT;
  localparam int BUS_W    = NUM_PORTS * PORT_WIDTH;

  logic                  addr_in_range;
  int                    chan_idx;
  io_reg_e               reg_sel;
  logic [BUS_W-1:0]      in_sync_bus;
  logic [BUS_W-1:0]      flags_bus;
  logic [BUS_W-1:0]      mask_bus;
  logic [NUM_PORTS-1:0]  irq_vec;
  logic [PORT_WIDTH-1:0] rd_field;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  valid_reg;
  logic                  irq_reg;

  assign addr_in_range = int'(bus.in_addr) < NUM_REGS;
  assign chan_idx      = int'(bus.in_addr[ADDR_WIDTH-1:2]);
  assign reg_sel       = io_reg_e'(bus.in_addr[1:0]);

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : gen_chan
      logic [PORT_WIDTH-1:0] sync_val;
      logic [PORT_WIDTH-1:0] edge_vec;
      logic [PORT_WIDTH-1:0] out_reg;
      logic [PORT_WIDTH-1:0] flags_reg;
      logic [PORT_WIDTH-1:0] mask_reg;
      logic [PORT_WIDTH-1:0] clr_vec;
      logic                  sel;

      io_sync_edge #(.PORT_WIDTH(PORT_WIDTH)) u_sync_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .pin      (in_port[gi*PORT_WIDTH +: PORT_WIDTH]),
        .sync_val (sync_val),
        .edge_vec (edge_vec)
      );

      assign sel     = bus.in_write_en && addr_in_range && (chan_idx == gi);
      assign clr_vec = (sel && reg_sel == IO_REG_FLAGS) ? bus.in_data[PORT_WIDTH-1:0] : '0;

      // OR-ing edges in after the clear makes a same-cycle set beat the W1C.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_reg   <= '0;
          flags_reg <= '0;
          mask_reg  <= '0;
        end else begin
          if (sel && reg_sel == IO_REG_OUT)  out_reg  <= bus.in_data[PORT_WIDTH-1:0];
          if (sel && reg_sel == IO_REG_MASK) mask_reg <= bus.in_data[PORT_WIDTH-1:0];
          flags_reg <= (flags_reg & ~clr_vec) | edge_vec;
        end
      end

      assign in_sync_bus[gi*PORT_WIDTH +: PORT_WIDTH] = sync_val;
      assign out_port[gi*PORT_WIDTH +: PORT_WIDTH]    = out_reg;
      assign flags_bus[gi*PORT_WIDTH +: PORT_WIDTH]   = flags_reg;
      assign mask_bus[gi*PORT_WIDTH +: PORT_WIDTH]    = mask_reg;
      assign irq_vec[gi]                              = |(flags_reg & mask_reg);
    end
  endgenerate

  always_comb begin
    rd_field = '0;
    if (addr_in_range) begin
      case (reg_sel)
        IO_REG_IN:    rd_field = in_sync_bus[chan_idx*PORT_WIDTH +: PORT_WIDTH];
        IO_REG_OUT:   rd_field = out_port[chan_idx*PORT_WIDTH +: PORT_WIDTH];
        IO_REG_FLAGS: rd_field = flags_bus[chan_idx*PORT_WIDTH +: PORT_WIDTH];
        IO_REG_MASK:  rd_field = mask_bus[chan_idx*PORT_WIDTH +: PORT_WIDTH];
        default:      rd_field = '0;
      endcase
    end
  end

  // Read data is forced to zero whenever valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
      irq_reg   <= 1'b0;
    end else begin
      valid_reg <= bus.in_read_en;
      data_reg  <= bus.in_read_en ? DATA_WIDTH'(rd_field) : '0;
      irq_reg   <= |irq_vec;
    end
  end

  assign bus.out_data       = data_reg;
  assign bus.out_data_valid = valid_reg;
  assign out_irq            = irq_reg;
endmodule

// File: tb/tb_io_port_bank.sv
// Directed bench for io_port_bank; expected reads are queued at issue and checked by a negedge monitor.
`timescale 1ns/1ps
module tb_io_port_bank;
  logic       clk;
  logic       rst_n;
  logic [7:0] in_port;
  logic [7:0] out_port;
  logic       out_irq;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  io_port_bank_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

  io_port_bank #(
    .DATA_WIDTH(8), .PORT_WIDTH(4), .NUM_PORTS(2), .ADDR_WIDTH(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .in_port  (in_port),
    .out_port (out_port),
    .out_irq  (out_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h @%0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h @%0t", name, act, $time);
    end
  endtask

  // Bus tasks start on a negedge and return on the next one, so calls run back to back.
  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    bus.in_write_en = 1'b1;
    bus.in_addr     = a;
    bus.in_data     = d;
    @(negedge clk);
    bus.in_write_en = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, input logic [7:0] exp);
    exp_t e;
    e.addr = a;
    e.data = exp;
    exp_q.push_back(e);
    bus.in_read_en = 1'b1;
    bus.in_addr    = a;
    @(negedge clk);
    bus.in_read_en = 1'b0;
  endtask

  task automatic do_rw(input logic [3:0] a, input logic [7:0] d, input logic [7:0] exp);
    exp_t e;
    e.addr = a;
    e.data = exp;
    exp_q.push_back(e);
    bus.in_read_en  = 1'b1;
    bus.in_write_en = 1'b1;
    bus.in_addr     = a;
    bus.in_data     = d;
    @(negedge clk);
    bus.in_read_en  = 1'b0;
    bus.in_write_en = 1'b0;
  endtask

  // Monitor: every valid read pops one expectation; idle cycles must show zero data.
  always @(negedge clk) begin
    if (bus.out_data_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got data=%0h want no read @%0t", bus.out_data, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("read[%0h]", e.addr), 32'(bus.out_data), 32'(e.data));
      end
    end else if (rst_n) begin
      check("idle_data_zero", 32'(bus.out_data), 32'h0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n           = 1'b0;
    in_port         = 8'hFF;
    bus.in_write_en = 1'b0;
    bus.in_read_en  = 1'b0;
    bus.in_addr     = '0;
    bus.in_data     = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(bus.out_data_valid), 0);
    check("rst_port", 32'(out_port), 0);
    check("rst_irq", 32'(out_irq), 0);

    // Release with pins high: IN visible after 2 clk, flags on the 3rd.
    rst_n = 1'b1;
    check("rel_port", 32'(out_port), 0);
    do_read(4'h0, 8'h00);
    do_read(4'h0, 8'h00);
    do_read(4'h2, 8'h00);
    do_read(4'h0, 8'h0F);
    do_read(4'h2, 8'h0F);
    do_read(4'h6, 8'h0F);
    do_read(4'h4, 8'h0F);
    check("rel_irq_masked", 32'(out_irq), 0);
    do_write(4'h2, 8'h0F);
    do_write(4'h6, 8'h0F);
    do_read(4'h2, 8'h00);
    do_read(4'h6, 8'h00);

    // OUT registers, width rules, IN write ignored, read+write same cycle.
    do_write(4'h1, 8'h0A);
    check("out_port_lo", 32'(out_port[3:0]), 32'hA);
    do_read(4'h1, 8'h0A);
    do_write(4'h5, 8'hFF);
    check("out_port_both", 32'(out_port), 32'hFA);
    do_read(4'h5, 8'h0F);
    do_write(4'h0, 8'h05);
    do_read(4'h0, 8'h0F);
    do_rw(4'h1, 8'h03, 8'h0A);
    do_read(4'h1, 8'h03);
    check("out_port_rw", 32'(out_port), 32'hF3);

    // Edge capture and irq timing on channel 0 bit 0.
    in_port = 8'h00;
    repeat (4) @(negedge clk);
    do_write(4'h2, 8'h0F);
    do_write(4'h6, 8'h0F);
    do_write(4'h3, 8'h01);
    do_read(4'h3, 8'h01);
    do_read(4'h2, 8'h00);
    check("irq_idle", 32'(out_irq), 0);
    in_port = 8'h01;
    repeat (2) @(negedge clk);
    do_read(4'h2, 8'h00);
    check("irq_before_flag", 32'(out_irq), 0);
    do_read(4'h2, 8'h01);
    check("irq_after_flag", 32'(out_irq), 1);
    do_write(4'h2, 8'h01);
    check("irq_lags_clear", 32'(out_irq), 1);
    do_read(4'h2, 8'h00);
    check("irq_cleared", 32'(out_irq), 0);

    // Falling edge lands in the same cycle as W1C of that bit: set wins.
    in_port = 8'h00;
    repeat (2) @(negedge clk);
    do_write(4'h2, 8'h01);
    do_read(4'h2, 8'h01);
    do_write(4'h2, 8'h01);
    do_read(4'h2, 8'h00);
    check("irq_after_race_clear", 32'(out_irq), 0);

    // Channel 1 with mask 0: flag still captured, irq stays low.
    in_port = 8'h10;
    repeat (3) @(negedge clk);
    do_read(4'h6, 8'h01);
    check("irq_unmasked_only", 32'(out_irq), 0);
    do_write(4'h6, 8'h01);

    // Out-of-range addresses.
    do_read(4'hC, 8'h00);
    do_read(4'hF, 8'h00);
    do_write(4'hD, 8'hFF);
    do_write(4'hC, 8'hFF);
    check("oor_out_port", 32'(out_port), 32'hF3);
    do_read(4'h3, 8'h01);
    do_read(4'h7, 8'h00);
    do_read(4'h1, 8'h03);
    do_read(4'h5, 8'h0F);
    do_read(4'h6, 8'h00);

    // Async reset during a read with an irq pending.
    do_write(4'h3, 8'h03);
    in_port = 8'h12;
    repeat (5) @(negedge clk);
    check("irq_pending", 32'(out_irq), 1);
    bus.in_read_en = 1'b1;
    bus.in_addr    = 4'h2;
    @(posedge clk);
    #1;
    check("midread_valid", 32'(bus.out_data_valid), 1);
    check("midread_data", 32'(bus.out_data), 32'h02);
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.out_data_valid), 0);
    check("arst_data", 32'(bus.out_data), 0);
    check("arst_irq", 32'(out_irq), 0);
    check("arst_port", 32'(out_port), 0);
    bus.in_read_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_read(4'h2, 8'h00);
    do_read(4'h6, 8'h00);
    do_read(4'h1, 8'h00);
    check("post_rst_irq", 32'(out_irq), 0);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
